// File: rtl/vga_scanout.sv
// VGA raster scanout: pixel-tick divider, lead H/V timing counters, multiplier-free
// framebuffer address generation and a latency-matched output stage.
module vga_scanout #(
   parameter int BITS_PER_PIXEL    = 4,
   parameter int H_VISIBLE         = 640,
   parameter int H_FRONT           = 16,
   parameter int H_SYNC            = 96,
   parameter int H_BACK            = 48,
   parameter int V_VISIBLE         = 480,
   parameter int V_FRONT           = 10,
   parameter int V_SYNC            = 2,
   parameter int V_BACK            = 33,
   parameter int CLOCK_DIVIDE      = 4,
   parameter int FB_LATENCY        = 1,
   parameter int SCALE_SHIFT       = 0,
   parameter bit HSYNC_ACTIVE_HIGH = 1'b0,
   parameter bit VSYNC_ACTIVE_HIGH = 1'b0
) (
   input  logic                      i_Clock,
   input  logic                      i_Reset,
   input  logic                      i_Enable,
   input  logic [BITS_PER_PIXEL-1:0] i_Fb_Read_Data,
   output logic [31:0]               o_Fb_Read_Addr,
   output logic                      o_Fb_Read_Enable,
   output logic [BITS_PER_PIXEL-1:0] o_RGB,
   output logic                      o_Horizontal_Sync,
   output logic                      o_Vertical_Sync,
   output logic                      o_Visible,
   output logic                      o_Vblank,
   output logic                      o_Frame_Start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int H_W     = $clog2(H_TOTAL);
   localparam int V_W     = $clog2(V_TOTAL);
   localparam int DIV_W   = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
   localparam int REP_W   = 2;

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLOCK_DIVIDE - 1);
   localparam logic [H_W-1:0]   H_LAST     = H_W'(H_TOTAL - 1);
   localparam logic [V_W-1:0]   V_LAST     = V_W'(V_TOTAL - 1);
   localparam logic [REP_W-1:0] REP_LAST   = REP_W'((1 << SCALE_SHIFT) - 1);
   localparam logic [H_W-1:0]   H_REP_MASK = H_W'((1 << SCALE_SHIFT) - 1);
   localparam logic [31:0]      ROW_STRIDE = 32'(H_VISIBLE >> SCALE_SHIFT);
   localparam logic             HS_ACTIVE  = HSYNC_ACTIVE_HIGH;
   localparam logic             VS_ACTIVE  = VSYNC_ACTIVE_HIGH;

   typedef enum logic [1:0] {
      REGION_VISIBLE,
      REGION_FRONT,
      REGION_SYNC,
      REGION_BACK
   } region_t;

   // All-zero stage means "blank, syncs inactive": the reset/idle state of the pipe.
   typedef struct packed {
      logic visible;
      logic hsync;
      logic vsync;
      logic vblank;
      logic frame_start;
   } stage_t;

   localparam int PIPE_W = FB_LATENCY * $bits(stage_t);

   function automatic region_t decode_region(input int pos, input int vis_len,
                                             input int front_len, input int sync_len);
      if (pos < vis_len)                             return REGION_VISIBLE;
      else if (pos < vis_len + front_len)            return REGION_FRONT;
      else if (pos < vis_len + front_len + sync_len) return REGION_SYNC;
      else                                           return REGION_BACK;
   endfunction

   logic [DIV_W-1:0]             div_count;
   logic [H_W-1:0]               h_count;
   logic [V_W-1:0]               v_count;
   logic [REP_W-1:0]             line_rep;
   logic [31:0]                  row_base;
   stage_t [FB_LATENCY-1:0]      pipe_q;
   stage_t                       out_stage;
   stage_t                       lead;
   region_t                      h_region;
   region_t                      v_region;
   logic                         tick;
   logic                         fetch;

   // NOTE: every variable is assigned on every pass through this block, so no
   // latch can be inferred; add a default first if a conditional assignment appears.
   always_comb begin
      tick             = (div_count == DIV_LAST);
      h_region         = decode_region(32'(h_count), H_VISIBLE, H_FRONT, H_SYNC);
      v_region         = decode_region(32'(v_count), V_VISIBLE, V_FRONT, V_SYNC);
      lead.visible     = (h_region == REGION_VISIBLE) && (v_region == REGION_VISIBLE);
      lead.hsync       = (h_region == REGION_SYNC);
      lead.vsync       = (v_region == REGION_SYNC);
      lead.vblank      = (v_region != REGION_VISIBLE);
      lead.frame_start = (h_count == '0) && (v_count == '0);
      // Replicated pixels reuse the word fetched for the first of the group.
      fetch            = lead.visible && ((h_count & H_REP_MASK) == '0);
   end

   assign out_stage = pipe_q[FB_LATENCY-1];

   // Lead timing and address generation. The row base steps by one scaled row
   // every 2^SCALE_SHIFT lines, so the address is an add, never a multiply.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         div_count        <= '0;
         h_count          <= '0;
         v_count          <= '0;
         line_rep         <= '0;
         row_base         <= '0;
         o_Fb_Read_Addr   <= '0;
         o_Fb_Read_Enable <= 1'b0;
      end else if (!i_Enable) begin
         div_count        <= '0;
         h_count          <= '0;
         v_count          <= '0;
         line_rep         <= '0;
         row_base         <= '0;
         o_Fb_Read_Addr   <= '0;
         o_Fb_Read_Enable <= 1'b0;
      end else begin
         o_Fb_Read_Enable <= 1'b0;
         div_count        <= tick ? '0 : div_count + 1'b1;
         if (tick) begin
            if (lead.visible) begin
               o_Fb_Read_Addr   <= row_base + (32'(h_count) >> SCALE_SHIFT);
               o_Fb_Read_Enable <= fetch;
            end
            if (h_count == H_LAST) begin
               h_count <= '0;
               if (v_count == V_LAST) begin
                  v_count  <= '0;
                  line_rep <= '0;
                  row_base <= '0;
               end else begin
                  v_count <= v_count + 1'b1;
                  if (line_rep == REP_LAST) begin
                     line_rep <= '0;
                     row_base <= row_base + ROW_STRIDE;
                  end else begin
                     line_rep <= line_rep + 1'b1;
                  end
               end
            end else begin
               h_count <= h_count + 1'b1;
            end
         end
      end
   end

   // Flag pipeline and output stage, both stepping on pixel ticks so the flags
   // meet the framebuffer data returned FB_LATENCY pixels after address issue.
   // NOTE: the pipeline is a short register chain, not a RAM, so it is reset to
   // keep the outputs defined while it refills after reset or enable.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         pipe_q            <= '0;
         o_RGB             <= '0;
         o_Visible         <= 1'b0;
         o_Vblank          <= 1'b0;
         o_Frame_Start     <= 1'b0;
         o_Horizontal_Sync <= ~HS_ACTIVE;
         o_Vertical_Sync   <= ~VS_ACTIVE;
      end else if (!i_Enable) begin
         pipe_q            <= '0;
         o_RGB             <= '0;
         o_Visible         <= 1'b0;
         o_Vblank          <= 1'b0;
         o_Frame_Start     <= 1'b0;
         o_Horizontal_Sync <= ~HS_ACTIVE;
         o_Vertical_Sync   <= ~VS_ACTIVE;
      end else begin
         o_Frame_Start <= 1'b0;
         if (tick) begin
            // Oldest stage drops off the top; the lead flags enter at stage 0.
            pipe_q            <= PIPE_W'({pipe_q, lead});
            o_RGB             <= out_stage.visible ? i_Fb_Read_Data : '0;
            o_Visible         <= out_stage.visible;
            o_Vblank          <= out_stage.vblank;
            o_Frame_Start     <= out_stage.frame_start;
            o_Horizontal_Sync <= out_stage.hsync ? HS_ACTIVE : ~HS_ACTIVE;
            o_Vertical_Sync   <= out_stage.vsync ? VS_ACTIVE : ~VS_ACTIVE;
         end
      end
   end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: three configurations against a position-arithmetic
// reference model, with directed and randomized reset / enable interruptions.
module tb_vga_scanout;

   localparam int N  = 3;
   localparam int HV = 8, HF = 2, HS = 2, HB = 2, HT = HV + HF + HS + HB;
   localparam int VV = 4, VF = 1, VS = 1, VB = 1, VT = VV + VF + VS + VB;
   localparam int CD_P  [N] = '{2, 2, 1};
   localparam int LAT_P [N] = '{1, 1, 3};
   localparam int SH_P  [N] = '{0, 1, 0};

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] addr   [N];
   logic        rd     [N];
   logic [3:0]  rgb    [N];
   logic        hsync  [N];
   logic        vsync  [N];
   logic        vis    [N];
   logic        vblank [N];
   logic        fstart [N];
   logic [31:0] fb_d0  [N];
   logic [31:0] fb_d1  [N];
   logic [3:0]  fb_a, fb_b, fb_c;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   int          k_m       [N];
   logic [31:0] last_addr [N];
   int          prev_fs   [N];
   int          strobes   [N];

   always #5 clk = ~clk;

   // Framebuffer: returns address[3:0] after LATENCY*DIVIDE-1 register stages.
   always @(posedge clk) begin
      for (int n = 0; n < N; n++) begin
         fb_d0[n] <= addr[n];
         fb_d1[n] <= fb_d0[n];
      end
   end
   assign fb_a = fb_d0[0][3:0];
   assign fb_b = fb_d0[1][3:0];
   assign fb_c = fb_d1[2][3:0];

   vga_scanout #(
      .BITS_PER_PIXEL(4), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .CLOCK_DIVIDE(2), .FB_LATENCY(1), .SCALE_SHIFT(0),
      .HSYNC_ACTIVE_HIGH(1'b0), .VSYNC_ACTIVE_HIGH(1'b0)
   ) u_a (
      .i_Clock(clk), .i_Reset(rst), .i_Enable(en), .i_Fb_Read_Data(fb_a),
      .o_Fb_Read_Addr(addr[0]), .o_Fb_Read_Enable(rd[0]), .o_RGB(rgb[0]),
      .o_Horizontal_Sync(hsync[0]), .o_Vertical_Sync(vsync[0]), .o_Visible(vis[0]),
      .o_Vblank(vblank[0]), .o_Frame_Start(fstart[0])
   );

   vga_scanout #(
      .BITS_PER_PIXEL(4), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .CLOCK_DIVIDE(2), .FB_LATENCY(1), .SCALE_SHIFT(1),
      .HSYNC_ACTIVE_HIGH(1'b0), .VSYNC_ACTIVE_HIGH(1'b0)
   ) u_b (
      .i_Clock(clk), .i_Reset(rst), .i_Enable(en), .i_Fb_Read_Data(fb_b),
      .o_Fb_Read_Addr(addr[1]), .o_Fb_Read_Enable(rd[1]), .o_RGB(rgb[1]),
      .o_Horizontal_Sync(hsync[1]), .o_Vertical_Sync(vsync[1]), .o_Visible(vis[1]),
      .o_Vblank(vblank[1]), .o_Frame_Start(fstart[1])
   );

   vga_scanout #(
      .BITS_PER_PIXEL(4), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .CLOCK_DIVIDE(1), .FB_LATENCY(3), .SCALE_SHIFT(0),
      .HSYNC_ACTIVE_HIGH(1'b0), .VSYNC_ACTIVE_HIGH(1'b0)
   ) u_c (
      .i_Clock(clk), .i_Reset(rst), .i_Enable(en), .i_Fb_Read_Data(fb_c),
      .o_Fb_Read_Addr(addr[2]), .o_Fb_Read_Enable(rd[2]), .o_RGB(rgb[2]),
      .o_Horizontal_Sync(hsync[2]), .o_Vertical_Sync(vsync[2]), .o_Visible(vis[2]),
      .o_Vblank(vblank[2]), .o_Frame_Start(fstart[2])
   );

   // Reference: pixel p of the endless raster sits at h = p % HT, v = (p / HT) % VT.
   function automatic logic [31:0] pix_addr(input int p, input int sh);
      int h;
      int v;
      h = p % HT;
      v = (p / HT) % VT;
      return 32'((v >> sh) * (HV >> sh) + (h >> sh));
   endfunction

   function automatic bit pix_vis(input int p);
      return ((p % HT) < HV) && (((p / HT) % VT) < VV);
   endfunction

   task automatic check(input string tag, input int n, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s dut=%0d cyc=%0d observed=%0h expected=%0h", tag, n, cyc, obs, exp);
      end
   endtask

   // Called after each rising edge: k counts enabled edges since the last clear.
   task automatic model_edge();
      for (int n = 0; n < N; n++) begin
         if (rst || !en) begin
            k_m[n]       = 0;
            last_addr[n] = '0;
         end else begin
            k_m[n]++;
            if (k_m[n] % CD_P[n] == 0 && pix_vis(k_m[n] / CD_P[n] - 1))
               last_addr[n] = pix_addr(k_m[n] / CD_P[n] - 1, SH_P[n]);
         end
      end
   endtask

   task automatic check_all();
      for (int n = 0; n < N; n++) begin
         int          j;
         int          q;
         int          h;
         int          v;
         int          lead_p;
         bit          tick_now;
         bit          active;
         logic [31:0] ea;
         logic        e_vis, e_hs, e_vs, e_vbl, e_fs, e_rd;
         logic [3:0]  e_rgb;
         j        = k_m[n] / CD_P[n];
         tick_now = (k_m[n] > 0) && (k_m[n] % CD_P[n] == 0);
         active   = (j > LAT_P[n]);
         q        = active ? (j - 1 - LAT_P[n]) : 0;
         h        = q % HT;
         v        = (q / HT) % VT;
         ea       = pix_addr(q, SH_P[n]);
         e_vis    = active && (h < HV) && (v < VV);
         e_rgb    = e_vis ? ea[3:0] : 4'h0;
         e_hs     = (active && h >= HV + HF && h < HV + HF + HS) ? 1'b0 : 1'b1;
         e_vs     = (active && v >= VV + VF && v < VV + VF + VS) ? 1'b0 : 1'b1;
         e_vbl    = active && (v >= VV);
         e_fs     = active && tick_now && (h == 0) && (v == 0);
         lead_p   = tick_now ? j - 1 : 0;
         e_rd     = tick_now && pix_vis(lead_p) && (((lead_p % HT) % (1 << SH_P[n])) == 0);
         check("rgb",         n, 32'(rgb[n]),    32'(e_rgb));
         check("fb_addr",     n, addr[n],        last_addr[n]);
         check("fb_rd_en",    n, 32'(rd[n]),     32'(e_rd));
         check("hsync",       n, 32'(hsync[n]),  32'(e_hs));
         check("vsync",       n, 32'(vsync[n]),  32'(e_vs));
         check("visible",     n, 32'(vis[n]),    32'(e_vis));
         check("vblank",      n, 32'(vblank[n]), 32'(e_vbl));
         check("frame_start", n, 32'(fstart[n]), 32'(e_fs));
      end
   endtask

   // Whole-frame properties: frame period and read strobes between frame starts.
   task automatic track_frames();
      for (int n = 0; n < N; n++) begin
         if (k_m[n] == 0) begin
            prev_fs[n] = -1;
            strobes[n] = 0;
         end else begin
            if (rd[n] === 1'b1) strobes[n]++;
            if (fstart[n] === 1'b1) begin
               if (prev_fs[n] >= 0) begin
                  check("frame_period", n, 32'(cyc - prev_fs[n]), 32'(HT * VT * CD_P[n]));
                  check("strobes_per_frame", n, 32'(strobes[n]), 32'((HV >> SH_P[n]) * VV));
               end
               prev_fs[n] = cyc;
               strobes[n] = 0;
            end
         end
      end
   endtask

   task automatic run(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
         cyc++;
         check_all();
         track_frames();
      end
   endtask

   // Asserts reset between edges and checks the outputs clear without a clock.
   task automatic pulse_reset(input int hold);
      #2;
      rst = 1'b1;
      for (int n = 0; n < N; n++) begin
         k_m[n]       = 0;
         last_addr[n] = '0;
      end
      #1;
      check_all();
      run(hold);
      rst = 1'b0;
   endtask

   task automatic drop_enable(input int cycles);
      en = 1'b0;
      run(cycles);
      en = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      en  = 1'b0;
      for (int n = 0; n < N; n++) begin
         k_m[n]       = 0;
         last_addr[n] = '0;
         prev_fs[n]   = -1;
         strobes[n]   = 0;
      end
      #1;
      check_all();
      run(2);
      en = 1'b1;
      run(2);
      rst = 1'b0;

      // Free run over several frames.
      run(3 * HT * VT * 2 + 7);

      // Reset while the first configuration's lead position is V=2, H=5.
      pulse_reset(2);
      run((2 * HT + 5) * 2);
      pulse_reset(3);
      run(400);

      // Enable low for 10 cycles, then restart from (0,0).
      drop_enable(10);
      run(300);

      // Randomized interruptions.
      for (int r = 0; r < 6; r++) begin
         run($urandom_range(20, 300));
         if ($urandom_range(0, 1) == 1) pulse_reset($urandom_range(1, 4));
         else                           drop_enable($urandom_range(1, 20));
      end
      run(450);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 BITS_PER_PIXEL, 4, width of each framebuffer pixel and of o_RGB.
REQ-002 H_VISIBLE/H_FRONT/H_SYNC/H_BACK, 640/16/96/48, horizontal timing in pixels; H_TOTAL is their sum.
REQ-003 V_VISIBLE/V_FRONT/V_SYNC/V_BACK, 480/10/2/33, vertical timing in lines; V_TOTAL is their sum.
REQ-004 CLOCK_DIVIDE, 4, i_Clock cycles per pixel (legal range 1..16).
REQ-005 FB_LATENCY, 1, pixel periods from address issue to data capture (legal range 1..4).
REQ-006 SCALE_SHIFT, 0, pixel/line replication factor 2^SCALE_SHIFT (legal values 0..2).
REQ-007 HSYNC_ACTIVE_HIGH/VSYNC_ACTIVE_HIGH, 0/0, sync polarity (0 = active low).
REQ-008 i_Clock  in  1  system clock; all state on the rising edge.
REQ-009 i_Reset  in  1  asynchronous, active-high reset.
REQ-010 i_Enable  in  1  scanout run; low forces the idle state.
REQ-011 i_Fb_Read_Data  in  BITS_PER_PIXEL  framebuffer read data.
REQ-012 o_Fb_Read_Addr  out  32  framebuffer pixel address.
REQ-013 o_Fb_Read_Enable  out  1  one-cycle read strobe.
REQ-014 o_RGB  out  BITS_PER_PIXEL  pixel output, zero outside the visible area.
REQ-015 o_Horizontal_Sync / o_Vertical_Sync  out  1  sync outputs at the configured polarity.
REQ-016 o_Visible / o_Vblank / o_Frame_Start  out  1  output-aligned visible flag, vertical-blank flag, and one-cycle frame-start pulse.

Function
REQ-017 The pixel tick SHALL be one i_Clock cycle in every CLOCK_DIVIDE cycles, generated by a divider counter running 0..CLOCK_DIVIDE-1; with CLOCK_DIVIDE=1 every cycle is a tick.
REQ-018 The lead counters H (0..H_TOTAL-1) and V (0..V_TOTAL-1) SHALL advance on each tick; H wraps to 0 and V increments on that wrap; V wraps to 0 after V_TOTAL-1.
REQ-019 Region decode SHALL be: visible when counter < VISIBLE; front porch when < VISIBLE+FRONT; sync when < VISIBLE+FRONT+SYNC; otherwise back porch.
REQ-020 On a tick where the lead position is visible, the block SHALL register o_Fb_Read_Addr = (V>>SCALE_SHIFT)*(H_VISIBLE>>SCALE_SHIFT) + (H>>SCALE_SHIFT) and pulse o_Fb_Read_Enable for exactly one cycle.
REQ-021 The address SHALL be produced by an incremental row-base accumulator; the implementation contains no multiplier.
REQ-022 Outside the visible area, o_Fb_Read_Enable SHALL be 0 and o_Fb_Read_Addr SHALL hold its last value.
REQ-023 Sync, visible and region flags SHALL pass through a FB_LATENCY-stage pipeline that advances on ticks only, so every output is aligned with the returned pixel data.
REQ-024 On each tick, o_RGB SHALL be loaded with i_Fb_Read_Data if the delayed visible flag is set and with 0 otherwise; o_RGB holds between ticks.
REQ-025 o_Vblank SHALL be 1 while the delayed V is >= V_VISIBLE.
REQ-026 o_Frame_Start SHALL pulse for one i_Clock cycle, on the cycle the output stage takes position (0,0).
REQ-027 Each sync output SHALL be at its active level when its delayed region is sync, and at its inactive level otherwise.
REQ-028 When i_Enable is low, the divider, counters, pipeline and accumulator SHALL clear synchronously to the idle state, with all outputs at their reset values.
REQ-029 After i_Enable rises, the first tick SHALL occur CLOCK_DIVIDE cycles later, and scanout SHALL start at (0,0).
REQ-030 On the simultaneous H wrap and V wrap, the row base SHALL return to 0 on the same tick.

Reset
REQ-031 While i_Reset is high, independent of the clock, all counters, the pipeline and the accumulator SHALL be 0; o_RGB = 0; o_Fb_Read_Addr = 0; o_Fb_Read_Enable, o_Visible, o_Vblank and o_Frame_Start = 0; each sync output is at its inactive level.
REQ-032 A reset asserted mid-line or mid-frame SHALL abandon the frame; after release, scanout SHALL restart at (0,0) as in REQ-029.

Verification
Bench parameters: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7), CLOCK_DIVIDE 2, FB_LATENCY 1, active-low syncs, unless noted.
REQ-033 Free run -> o_Frame_Start pulses exactly every 196 cycles; o_Horizontal_Sync is low for 4 cycles per line starting at output H=10; o_Vertical_Sync is low for exactly one line (28 cycles) per frame.
REQ-034 Framebuffer model returning data = address[3:0] one pixel later -> o_RGB shows 0..7 on line 0 and 8..15 on line 1, and is 0 during blanking.
REQ-035 SCALE_SHIFT=1 -> addresses per line are 0,0,1,1,2,2,3,3; lines 0 and 1 repeat row 0; line 2 starts at address 4; 16 read strobes per frame.
REQ-036 i_Reset pulsed at V=2, H=5 -> outputs reach reset values immediately; after release, the first o_Fb_Read_Addr is 0 and o_Frame_Start arrives on schedule.
REQ-037 i_Enable low for 10 cycles, then high -> outputs stay idle while low, and scanout restarts from (0,0).
REQ-038 CLOCK_DIVIDE=1, FB_LATENCY=3 -> o_RGB, the syncs and o_Visible all shift by exactly 3 cycles relative to address issue, with no misalignment at line wrap.
